// File: rtl/sram_stream_pkg.sv
// Shared types and constants for the SRAM stream buffer: FSM encoding,
// default geometry and a width helper for derived localparams.
package sram_stream_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 784;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // Bits needed to index 'value' distinct items (value >= 1).
  function automatic int clog2(input int value);
    int width;
    int rem;
    width = 0;
    rem   = value - 1;
    while (rem > 0) begin
      width++;
      rem = rem >> 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/sram_sp_array.sv
// Raw DATA_W x DEPTH storage: one write port, one synchronous read port,
// read-before-write on an address collision.
module sram_sp_array
  import sram_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = clog2(DEF_DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: no reset here, so the array maps onto SRAM macros / block RAM; a
  // reset would force flops and a clear sequencer.
  // NOTE: non-blocking assignments make the read sample the pre-write word
  // when both ports hit the same address in one cycle.
  always_ff @(posedge clk) begin
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

endmodule

// File: rtl/sram_stream_buf.sv
// Frame SRAM with a direct write port and a circular burst-read engine that
// streams words over valid/ready through a 2-entry skid register.
module sram_stream_buf
  import sram_stream_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = clog2(DEPTH),
  localparam int LEN_W  = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_err,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done
);

  localparam logic [LEN_W-1:0]  DEPTH_L  = LEN_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_in_flight, r_if_last;
  logic [1:0]        r_held;
  logic [DATA_W-1:0] r_q0_data, r_q1_data;
  logic              r_q0_last, r_q1_last;
  logic              r_wr_err, r_rd_err, r_done;

  logic              w_wr_ok, w_idle_req, w_req_bad, w_req_zero, w_req_go;
  logic              w_pop, w_issue, w_issue_last, w_final_pop;
  logic [2:0]        w_occ;
  logic [DATA_W-1:0] w_rd_data;

  assign w_wr_ok      = wr_en && (LEN_W'(wr_addr) < DEPTH_L);
  assign w_idle_req   = rd_start && (r_state == ST_IDLE);
  assign w_req_bad    = w_idle_req && ((LEN_W'(rd_base) >= DEPTH_L) || (rd_len > DEPTH_L));
  assign w_req_zero   = w_idle_req && !w_req_bad && (rd_len == '0);
  assign w_req_go     = w_idle_req && !w_req_bad && (rd_len != '0);

  // Issue only while the skid can still absorb the word that comes back.
  assign w_pop        = out_valid && out_ready;
  assign w_occ        = {1'b0, r_held} + {2'b00, r_in_flight} - {2'b00, w_pop};
  assign w_issue      = (r_state == ST_RUN) && (r_remaining != '0) && (w_occ < 3'd2);
  assign w_issue_last = w_issue && (r_remaining == LEN_W'(1));
  assign w_final_pop  = (r_state == ST_DRAIN) && w_pop && r_q0_last;

  sram_sp_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk       (clk),
    .i_wr_en   (w_wr_ok),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_en   (w_issue),
    .i_rd_addr (r_ptr),
    .o_rd_data (w_rd_data)
  );

  // NOTE: next state gets its default first so no path through the case
  // leaves it unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_req_go)     w_state_nxt = ST_RUN;
      ST_RUN:   if (w_issue_last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_final_pop)  w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_in_flight <= 1'b0;
      r_if_last   <= 1'b0;
      r_wr_err    <= 1'b0;
      r_rd_err    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_flight <= w_issue;
      r_if_last   <= w_issue_last;
      r_wr_err    <= wr_en && !w_wr_ok;
      r_rd_err    <= w_req_bad;
      r_done      <= w_final_pop || w_req_zero;
      if (w_req_go) begin
        r_ptr       <= rd_base;
        r_remaining <= rd_len;
      end else if (w_issue) begin
        r_ptr       <= (r_ptr == LAST_ADR) ? '0 : r_ptr + ADDR_W'(1);
        r_remaining <= r_remaining - LEN_W'(1);
      end
    end
  end

  // Two-entry skid: q0 is the presented beat, q1 catches the in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held    <= 2'd0;
      r_q0_data <= '0;
      r_q1_data <= '0;
      r_q0_last <= 1'b0;
      r_q1_last <= 1'b0;
    end else begin
      case ({r_in_flight, w_pop})
        2'b10: begin
          if (r_held == 2'd0) begin
            r_q0_data <= w_rd_data;
            r_q0_last <= r_if_last;
          end else begin
            r_q1_data <= w_rd_data;
            r_q1_last <= r_if_last;
          end
          r_held <= r_held + 2'd1;
        end
        2'b01: begin
          r_q0_data <= r_q1_data;
          r_q0_last <= r_q1_last;
          r_held    <= r_held - 2'd1;
        end
        2'b11: begin
          if (r_held == 2'd1) begin
            r_q0_data <= w_rd_data;
            r_q0_last <= r_if_last;
          end else begin
            r_q0_data <= r_q1_data;
            r_q0_last <= r_q1_last;
            r_q1_data <= w_rd_data;
            r_q1_last <= r_if_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_held != 2'd0);
  assign out_data  = r_q0_data;
  assign out_last  = r_q0_last && out_valid;
  assign wr_err    = r_wr_err;
  assign rd_err    = r_rd_err;
  assign done      = r_done;

endmodule
